// File: rtl/pipe_hazard_ctrl.sv
// Hazard, interlock and forwarding controller for the five-stage miniLA pipeline.
// Shadows in-flight destinations and sequences freeze, redirect flush and load-use bubbles.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned SCNT_W = 32,
  parameter int unsigned FCNT_W = 16
) (
  input  logic              cpu_clk,
  input  logic              cpu_rstn,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_re1,
  input  logic              id_re2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_we,
  input  logic              id_load,
  input  logic              ex_redirect,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              ifid_flush,
  output logic              idex_stall,
  output logic              idex_flush,
  output logic              exmem_stall,
  output logic              memwb_flush,
  output logic [1:0]        fwd1_sel,
  output logic [1:0]        fwd2_sel,
  output logic [SCNT_W-1:0] stall_cnt,
  output logic [FCNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_src_e;

  logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;
  logic              ex_we, mem_we, wb_we;
  logic              ex_valid, mem_valid, wb_valid;
  logic              ex_load;
  logic [SCNT_W-1:0] stall_q;
  logic [FCNT_W-1:0] flush_q;

  logic     freeze, redirect, lu, luse, flush_ex;
  fwd_src_e src1, src2;

  // Youngest writer wins; an EX load is skipped because the load-use bubble covers it.
  function automatic fwd_src_e pick_src(input logic [REG_AW-1:0] rs, input logic re);
    pick_src = FWD_RF;
    if (re && rs != '0) begin
      if (wb_valid && wb_we && wb_rd == rs)              pick_src = FWD_WB;
      if (mem_valid && mem_we && mem_rd == rs)           pick_src = FWD_MEM;
      if (ex_valid && ex_we && !ex_load && ex_rd == rs)  pick_src = FWD_EX;
    end
  endfunction

  always_comb begin
    freeze   = mem_req & ~mem_ready;
    redirect = ex_redirect & ~freeze;
    lu       = ex_valid & ex_load & ex_we & (ex_rd != '0) & id_valid &
               ((id_re1 & (id_rs1 == ex_rd)) | (id_re2 & (id_rs2 == ex_rd)));
    luse     = lu & ~freeze & ~redirect;
    flush_ex = redirect | luse;
    src1     = pick_src(id_rs1, id_re1);
    src2     = pick_src(id_rs2, id_re2);
  end

  // Strobes are gated by reset so the pipeline sees no control activity while held.
  always_comb begin
    pc_stall    = cpu_rstn & (freeze | luse);
    ifid_stall  = cpu_rstn & (freeze | luse);
    ifid_flush  = cpu_rstn & redirect;
    idex_stall  = cpu_rstn & freeze;
    idex_flush  = cpu_rstn & flush_ex;
    exmem_stall = cpu_rstn & freeze;
    memwb_flush = cpu_rstn & freeze;
    fwd1_sel    = cpu_rstn ? src1 : FWD_RF;
    fwd2_sel    = cpu_rstn ? src2 : FWD_RF;
    stall_cnt   = stall_q;
    flush_cnt   = flush_q;
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      ex_rd     <= '0;
      ex_we     <= 1'b0;
      ex_valid  <= 1'b0;
      ex_load   <= 1'b0;
      mem_rd    <= '0;
      mem_we    <= 1'b0;
      mem_valid <= 1'b0;
      wb_rd     <= '0;
      wb_we     <= 1'b0;
      wb_valid  <= 1'b0;
    end else if (!freeze) begin
      wb_rd     <= mem_rd;
      wb_we     <= mem_we;
      wb_valid  <= mem_valid;
      mem_rd    <= ex_rd;
      mem_we    <= ex_we;
      mem_valid <= ex_valid;
      if (flush_ex) begin
        ex_rd    <= '0;
        ex_we    <= 1'b0;
        ex_valid <= 1'b0;
        ex_load  <= 1'b0;
      end else begin
        ex_rd    <= id_rd;
        ex_we    <= id_we & id_valid;
        ex_valid <= id_valid;
        ex_load  <= id_load;
      end
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if ((freeze | luse) && stall_q != '1) stall_q <= stall_q + SCNT_W'(1);
      if (redirect && flush_q != '1)        flush_q <= flush_q + FCNT_W'(1);
    end
  end

endmodule
